// File: rtl/fpga_template_pkg.sv
// Shared definitions for the ping-pong drain controller.
// Holds the drain FSM state encoding and the default read latency of the
// ping-pong buffer RAM, so that the controller and any neighbouring blocks
// agree on both.
package fpga_template_pkg;

  // Default number of cycles from a stable read address to valid read data.
  localparam int RD_LAT_DEFAULT = 2;

  // Drain FSM states: idle, waiting out the read latency, presenting a beat.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/pingpong_drain_ctrl.sv
// Ping-pong buffer drain controller.
// When a half-buffer fills (buffer_ready_i), the controller reads its DEPTH
// samples one at a time and presents each as a beat on a valid/ready stream.
// The last beat of a complete frame carries m_last_o.
//
// Ports:
//   clk_i, rst_i       clock and synchronous active-high reset
//   enable_i           allows a new frame to start; frames arriving while low
//                      are counted in drop_count_o (saturating)
//   buffer_ready_i     one-cycle pulse: a half-buffer is full, read ptr at 0
//   read_enable_i      buffer has readable data
//   read_data_i        sample at the current buffer read address
//   read_ack_o         one-cycle pulse advancing the buffer read address
//   m_data_o/m_valid_o/m_ready_i/m_last_o   downstream stream
//   busy_o             controller is not idle
//   frame_count_o      completed frames (wraps)
//   overrun_o          sticky: a new buffer arrived while a frame was draining
//   drop_count_o       frames ignored while enable_i was low (saturates)
module pingpong_drain_ctrl
  import fpga_template_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = RD_LAT_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             buffer_ready_i,
  input  logic             read_enable_i,
  input  logic [WIDTH-1:0] read_data_i,
  output logic             read_ack_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_last_o,
  output logic             busy_o,
  output logic [15:0]      frame_count_o,
  output logic             overrun_o,
  output logic [7:0]       drop_count_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(RD_LAT + 2);

  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DEPTH - 1);
  // read_ack_o is registered, so the buffer address moves at the end of the
  // first OUT cycle. The first WAIT cycle lets that address settle, and the
  // next RD_LAT cycles cover the RAM latency. Capturing at count RD_LAT gives
  // one beat every RD_LAT+2 cycles.
  localparam logic [CNT_W-1:0] CNT_CAPTURE = CNT_W'(RD_LAT);

  drain_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ack_q, ack_d;
  logic             trunc_q, trunc_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      frame_q, frame_d;
  logic [7:0]       drop_q, drop_d;

  // State and output registers. Reset returns everything to idle/zero and
  // discards any beat in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      trunc_q   <= 1'b0;
      overrun_q <= 1'b0;
      frame_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ack_q     <= ack_d;
      trunc_q   <= trunc_d;
      overrun_q <= overrun_d;
      frame_q   <= frame_d;
      drop_q    <= drop_d;
    end
  end

  // Next-state logic for the drain FSM and its counters.
  // A beat is "truncated" when a new buffer arrives while that beat is on
  // the stream. It still completes its handshake, but without m_last_o, and
  // the drain then restarts at index 0 of the new buffer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ack_d     = 1'b0;
    trunc_d   = trunc_q;
    overrun_d = overrun_q;
    frame_d   = frame_q;
    drop_d    = drop_q;

    unique case (state_q)
      S_IDLE: begin
        if (buffer_ready_i) begin
          if (enable_i) begin
            state_d = S_WAIT;
            idx_d   = '0;
            cnt_d   = '0;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end

      S_WAIT: begin
        if (buffer_ready_i) begin
          overrun_d = 1'b1;
          idx_d     = '0;
          cnt_d     = '0;
        end else if (cnt_q == CNT_CAPTURE) begin
          // The counter holds here until the buffer reports readable data.
          if (read_enable_i) begin
            data_d  = read_data_i;
            ack_d   = 1'b1;
            valid_d = 1'b1;
            state_d = S_OUT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_OUT: begin
        if (m_ready_i) begin
          valid_d = 1'b0;
          trunc_d = 1'b0;
          cnt_d   = '0;
          if ((idx_q == IDX_LAST) && !trunc_q) begin
            // A buffer arriving on the final handshake is a clean back-to-back
            // frame, not an overrun.
            frame_d = frame_q + 16'd1;
            idx_d   = '0;
            if (buffer_ready_i && enable_i) begin
              state_d = S_WAIT;
            end else begin
              state_d = S_IDLE;
              if (buffer_ready_i && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
              end
            end
          end else begin
            state_d = S_WAIT;
            if (trunc_q || buffer_ready_i) begin
              idx_d = '0;
              if (buffer_ready_i) begin
                overrun_d = 1'b1;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end else if (buffer_ready_i) begin
          overrun_d = 1'b1;
          trunc_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign read_ack_o    = ack_q;
  assign m_data_o      = data_q;
  assign m_valid_o     = valid_q;
  assign m_last_o      = valid_q && (idx_q == IDX_LAST) && !trunc_q;
  assign busy_o        = (state_q != S_IDLE);
  assign frame_count_o = frame_q;
  assign overrun_o     = overrun_q;
  assign drop_count_o  = drop_q;

endmodule
